mips_prog_encoder: RTL

Program loader for the pipelined MIPS core. It accepts symbolic instruction requests (kind plus register, immediate and target fields) over a valid/ready handshake. It encodes each request into a 32-bit MIPS word using the same opcode map the ID-stage control decoder consumes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010. Words are written sequentially into instruction memory through a single write port, so benches and boot logic can build programs without hand-assembled hex.

---
 rtl/mips_prog_encoder_if.sv | 26 ++
 rtl/mips_prog_encoder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mips_prog_encoder_if.sv
// Request channel of the MIPS program loader: one symbolic instruction per
// valid/ready handshake. The loader is the slave; the program source is the master.
interface mips_prog_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_kind;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [4:0]  req_shamt;
  logic [5:0]  req_funct;
  logic [15:0] req_imm;
  logic [25:0] req_target;

  modport master (
    output req_valid, req_kind, req_rs, req_rt, req_rd,
           req_shamt, req_funct, req_imm, req_target,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_kind, req_rs, req_rt, req_rd,
           req_shamt, req_funct, req_imm, req_target,
    output req_ready
  );
endinterface

// File: rtl/mips_prog_encoder.sv
// Encodes symbolic MIPS requests into 32-bit words and writes them sequentially
// into instruction memory. Define ENC_NOP_PAD_EN to NOP-fill the rest of memory on finish.
module mips_prog_encoder #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  finish,
  mips_prog_encoder_if.slave    bus,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  loaded,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_FULL = 3'd2,
`ifdef ENC_NOP_PAD_EN
    S_PAD  = 3'd3,
`endif
    S_DONE = 3'd4
  } state_t;

  // Opcodes shared with the ID-stage control decoder.
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [2:0] K_R   = 3'd0;
  localparam logic [2:0] K_LW  = 3'd1;
  localparam logic [2:0] K_SW  = 3'd2;
  localparam logic [2:0] K_BEQ = 3'd3;
  localparam logic [2:0] K_J   = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_n, addr_n;
  logic [ADDR_WIDTH:0]   count_n;
  logic [31:0]           data_n, enc_word;
  logic                  we_q, we_n;
  logic                  err_n, full_n, loaded_n;
  logic                  accept, legal, wrote, at_last;

  assign bus.req_ready = (state == S_LOAD);
  assign accept        = (state == S_LOAD) & bus.req_valid;
  assign legal         = (bus.req_kind <= K_J);
  assign wrote         = accept & legal;
  assign at_last       = (wr_ptr == LAST_ADDR);

  // A synchronous reset still has to kill the strobe of a word registered just before it.
  assign imem_we = we_q & ~rst;

  always_comb begin
    enc_word = '0;
    case (bus.req_kind)
      K_R:     enc_word = {OP_R, bus.req_rs, bus.req_rt, bus.req_rd, bus.req_shamt, bus.req_funct};
      K_LW:    enc_word = {OP_LW, bus.req_rs, bus.req_rt, bus.req_imm};
      K_SW:    enc_word = {OP_SW, bus.req_rs, bus.req_rt, bus.req_imm};
      K_BEQ:   enc_word = {OP_BEQ, bus.req_rs, bus.req_rt, bus.req_imm};
      K_J:     enc_word = {OP_J, bus.req_target};
      default: enc_word = '0;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_n  = state;
    wr_ptr_n = wr_ptr;
    count_n  = count;
    err_n    = err;
    full_n   = full;
    we_n     = 1'b0;
    addr_n   = imem_addr;
    data_n   = imem_wdata;

    case (state)
      S_IDLE, S_DONE, S_FULL: begin
        if (start) begin
          state_n  = S_LOAD;
          wr_ptr_n = '0;
          count_n  = '0;
          err_n    = 1'b0;
          full_n   = 1'b0;
        end else if (state == S_FULL && finish) begin
          state_n = S_DONE;
        end
      end

      S_LOAD: begin
        if (accept && !legal) begin
          err_n = 1'b1;
        end
        if (wrote) begin
          we_n    = 1'b1;
          addr_n  = wr_ptr;
          data_n  = enc_word;
          count_n = count + 1'b1;
          if (at_last) full_n = 1'b1;
          else         wr_ptr_n = wr_ptr + 1'b1;
        end
        if (finish) begin
`ifdef ENC_NOP_PAD_EN
          // Nothing is left to pad once the last address has just been written.
          state_n = (wrote && at_last) ? S_DONE : S_PAD;
`else
          state_n = S_DONE;
`endif
        end else if (wrote && at_last) begin
          state_n = S_FULL;
        end
      end

`ifdef ENC_NOP_PAD_EN
      S_PAD: begin
        we_n   = 1'b1;
        addr_n = wr_ptr;
        data_n = 32'h0000_0000;
        if (at_last) state_n  = S_DONE;
        else         wr_ptr_n = wr_ptr + 1'b1;
      end
`endif

      default: state_n = S_IDLE;
    endcase

    // loaded waits until the final write strobe has been issued.
    loaded_n = (state_n == S_DONE) & ~we_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      count      <= '0;
      err        <= 1'b0;
      full       <= 1'b0;
      loaded     <= 1'b0;
      we_q       <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      count      <= count_n;
      err        <= err_n;
      full       <= full_n;
      loaded     <= loaded_n;
      we_q       <= we_n;
      imem_addr  <= addr_n;
      imem_wdata <= data_n;
    end
  end

endmodule
